mem_ram_ctrl: RTL and testbench
===============================

Name: mem_ram_ctrl

Overview:
Memory-stage initiator for the data RAM. It turns load/store micro-ops into RAM requests with byte lane selects, and stalls the pipeline until the RAM acknowledges. It aligns and sign- or zero-extends load data and presents pc, destination, write-enable and result to the MEM/WB register. This is the producer of the data that the write-back stage receives as RAM data.

Parameters:
TIMEOUT_CYCLES, 255, maximum cycles in ACCESS without ram_ack_i before a bus error (1..255).
ADDR_W, 32, RAM byte-address width.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
pc_i  in  32  instruction pc
mem_op_i  in  4  0 NONE, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 treated as NONE
mem_addr_i  in  ADDR_W  effective byte address
store_data_i  in  32  rt value for stores
wd_i  in  5  destination register
wreg_i  in  1  register write request from EX
wdata_i  in  32  ALU result
ram_ack_i  in  1  RAM completion, one cycle
ram_data_i  in  32  read data, valid with ram_ack_i
ram_ce_o  out  1  request strobe
ram_we_o  out  1  1 = write
ram_sel_o  out  4  byte enables
ram_addr_o  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
ram_data_o  out  32  lane-replicated store data
stallreq_o  out  1  hold IF..MEM
pc_o  out  32  to write-back
wd_o  out  5  to write-back
wreg_o  out  1  to write-back
wdata_o  out  32  to write-back
adel_o  out  1  load address error, one cycle
ades_o  out  1  store address error, one cycle
bus_err_o  out  1  RAM timeout, one cycle

Behaviour:
- Little-endian lanes: byte at addr[1:0]=k is bits [8k+7:8k], sel bit k. Half-word at addr[1]=h is sel 2'b11<<2h.
- Stores replicate data: SB {4{b}}, SH {2{h}}, SW the word.
- Misaligned access: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
  - Misaligned access issues no RAM request and no stall.
  - adel_o or ades_o is high combinationally while the op is presented in IDLE.
  - wreg_o is forced to 0.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE with an aligned memory op: next state ACCESS. stallreq_o=1 combinationally in that cycle.
  - ACCESS: ram_ce_o=1, ram_we_o, ram_sel_o, ram_addr_o and ram_data_o are registered and held stable. stallreq_o=1.
  - ACCESS with ram_ack_i: latch ram_data_i, go to DONE.
  - ACCESS with a counter reaching TIMEOUT_CYCLES: go to DONE with bus_err_o=1 in the DONE cycle. wreg_o is forced to 0 in DONE.
  - DONE: ram_ce_o=0, stallreq_o=0. Outputs carry the load result. Next state is IDLE unconditionally.
  - DONE is exactly one cycle, so an op held during the stall is never reissued.
- Minimum memory-op latency: 3 cycles (IDLE, ACCESS with ack, DONE). Each wait cycle adds one.
- Counter: 8-bit, cleared on entry to ACCESS.
- Write-back outputs:
  - pc_o, wd_o and wreg_o follow their inputs combinationally.
  - wdata_o = wdata_i for non-loads.
  - In DONE for loads: extracted lane, sign-extended for LB/LH, zero-extended for LBU/LHU.
  - Stores: wreg_o follows wreg_i (EX already drives 0).
- ram_ack_i outside ACCESS is ignored.
- Reset, including mid-ACCESS: state IDLE and counter 0. ram_ce_o, ram_we_o, ram_sel_o, ram_addr_o, ram_data_o, the latched load data, adel_o, ades_o and bus_err_o all go to 0. A pending RAM transaction is abandoned and its late ack is ignored.

Decomposition:
- Shared defines: the mem_op encodings, the FSM state encodings, and the widths RegBus=32 and RegAddrBus=5.
- One natural sub-module, load_align: combinational. It takes mem_op, addr[1:0] and a raw word and produces the extended result. The bench reuses it as a reference model.

Test Plan:
- SB addr 0x103, store_data 0x000000AB, ack after 2 waits -> ram_sel_o=4'b1000, ram_addr_o=0x100, ram_data_o=0xABABABAB, stallreq_o high for 4 cycles.
- LB addr 0x202, ram_data_i=0x0080FF00 with immediate ack -> wdata_o=0xFFFFFF80 in DONE with wreg_o=1. The same with LBU -> 0x00000080.
- LH addr 0x301 -> adel_o=1 for 1 cycle, ram_ce_o never asserted, stallreq_o=0, wreg_o=0.
- LW with no ack, TIMEOUT_CYCLES=4 -> ACCESS lasts 4 cycles, then bus_err_o=1 for 1 cycle, wreg_o=0, return to IDLE.
- rst asserted in the 2nd ACCESS cycle, ack arrives next cycle -> all outputs 0, state IDLE, no DONE pulse.
- Back-to-back LW 0x400 then SW 0x404, each acked immediately -> 6 cycles total, one ram_ce_o burst per op, no reissue.

Source files
------------

// File: rtl/mem_ram_ctrl_pkg.sv
// Shared encodings and lane helpers for the memory-stage RAM initiator.
// Op codes 9-15 are deliberately left out of the enum and decode as no access.
package mem_ram_ctrl_pkg;

  localparam int RegBus     = 32;
  localparam int RegAddrBus = 5;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LBU  = 4'd2,
    MEM_LH   = 4'd3,
    MEM_LHU  = 4'd4,
    MEM_LW   = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  function automatic logic is_load(input logic [3:0] op);
    return (op >= MEM_LB) && (op <= MEM_LW);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op >= MEM_SB) && (op <= MEM_SW);
  endfunction

  function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] lane);
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: return lane[0];
      MEM_LW, MEM_SW:          return |lane;
      default:                 return 1'b0;
    endcase
  endfunction

  // Little-endian byte enables: byte k drives sel[k], half h drives sel[2h+1:2h].
  function automatic logic [3:0] lane_sel(input logic [3:0] op, input logic [1:0] lane);
    case (op)
      MEM_LB, MEM_LBU, MEM_SB: return 4'b0001 << lane;
      MEM_LH, MEM_LHU, MEM_SH: return 4'b0011 << {lane[1], 1'b0};
      default:                 return 4'b1111;
    endcase
  endfunction

  function automatic logic [RegBus-1:0] store_lanes(input logic [3:0] op,
                                                    input logic [RegBus-1:0] data);
    case (op)
      MEM_SB:  return {4{data[7:0]}};
      MEM_SH:  return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/mem_ram_ctrl_load_align.sv
// Picks the addressed byte/half out of a RAM word and sign- or zero-extends it.
module mem_ram_ctrl_load_align
  import mem_ram_ctrl_pkg::*;
(
  input  logic [3:0]        mem_op,
  input  logic [1:0]        lane,
  input  logic [RegBus-1:0] word,
  output logic [RegBus-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    byte_sel = word[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? word[31:16] : word[15:0];
    result   = word;
    case (mem_op)
      MEM_LB:  result = {{24{byte_sel[7]}}, byte_sel};
      MEM_LBU: result = {24'd0, byte_sel};
      MEM_LH:  result = {{16{half_sel[15]}}, half_sel};
      MEM_LHU: result = {16'd0, half_sel};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_ram_ctrl.sv
// Memory-stage RAM initiator: issues one request per aligned load/store, stalls
// the pipeline until ack or timeout, and hands the aligned result to write-back.
module mem_ram_ctrl
  import mem_ram_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [RegBus-1:0]     pc_i,
  input  logic [3:0]            mem_op_i,
  input  logic [ADDR_W-1:0]     mem_addr_i,
  input  logic [RegBus-1:0]     store_data_i,
  input  logic [RegAddrBus-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic [RegBus-1:0]     wdata_i,
  input  logic                  ram_ack_i,
  input  logic [RegBus-1:0]     ram_data_i,
  output logic                  ram_ce_o,
  output logic                  ram_we_o,
  output logic [3:0]            ram_sel_o,
  output logic [ADDR_W-1:0]     ram_addr_o,
  output logic [RegBus-1:0]     ram_data_o,
  output logic                  stallreq_o,
  output logic [RegBus-1:0]     pc_o,
  output logic [RegAddrBus-1:0] wd_o,
  output logic                  wreg_o,
  output logic [RegBus-1:0]     wdata_o,
  output logic                  adel_o,
  output logic                  ades_o,
  output logic                  bus_err_o
);

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  state_e            state;
  logic [7:0]        wait_cnt;
  logic [3:0]        ld_op;
  logic [1:0]        ld_lane;
  logic [RegBus-1:0] ld_word;
  logic [RegBus-1:0] ld_result;

  logic [1:0] lane;
  logic       misaligned;
  logic       start;

  assign lane       = mem_addr_i[1:0];
  assign misaligned = is_misaligned(mem_op_i, lane);
  assign start      = (state == ST_IDLE) && (is_load(mem_op_i) || is_store(mem_op_i))
                      && !misaligned;

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      wait_cnt   <= 8'd0;
      ram_ce_o   <= 1'b0;
      ram_we_o   <= 1'b0;
      ram_sel_o  <= 4'd0;
      ram_addr_o <= '0;
      ram_data_o <= '0;
      ld_op      <= MEM_NONE;
      ld_lane    <= 2'd0;
      ld_word    <= '0;
      bus_err_o  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_ACCESS;
            wait_cnt   <= 8'd0;
            ram_ce_o   <= 1'b1;
            ram_we_o   <= is_store(mem_op_i);
            ram_sel_o  <= lane_sel(mem_op_i, lane);
            ram_addr_o <= {mem_addr_i[ADDR_W-1:2], 2'b00};
            ram_data_o <= store_lanes(mem_op_i, store_data_i);
            ld_op      <= mem_op_i;
            ld_lane    <= lane;
          end
        end
        ST_ACCESS: begin
          if (ram_ack_i) begin
            state    <= ST_DONE;
            ram_ce_o <= 1'b0;
            ld_word  <= ram_data_i;
          end else if (wait_cnt == TimeoutLast) begin
            state     <= ST_DONE;
            ram_ce_o  <= 1'b0;
            bus_err_o <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ST_DONE: begin
          // Unconditional return keeps the still-held op from being reissued.
          state     <= ST_IDLE;
          bus_err_o <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  mem_ram_ctrl_load_align u_load_align (
    .mem_op (ld_op),
    .lane   (ld_lane),
    .word   (ld_word),
    .result (ld_result)
  );

  assign stallreq_o = start || (state == ST_ACCESS);
  assign adel_o     = !rst && (state == ST_IDLE) && is_load(mem_op_i) && misaligned;
  assign ades_o     = !rst && (state == ST_IDLE) && is_store(mem_op_i) && misaligned;
  assign pc_o       = pc_i;
  assign wd_o       = wd_i;
  assign wreg_o     = wreg_i && !misaligned && !((state == ST_DONE) && bus_err_o);
  assign wdata_o    = ((state == ST_DONE) && is_load(ld_op)) ? ld_result : wdata_i;

endmodule

// File: tb/tb_mem_ram_ctrl.sv
// Directed bench for mem_ram_ctrl: lane selects, extension, misalignment,
// timeout, mid-access reset and back-to-back ops, all against fixed expectations.
module tb_mem_ram_ctrl;
  import mem_ram_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic [3:0]  mem_op_i;
  logic [31:0] mem_addr_i;
  logic [31:0] store_data_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic [31:0] wdata_i;
  logic        ram_ack_i;
  logic [31:0] ram_data_i;
  logic        ram_ce_o, ram_we_o, stallreq_o, wreg_o, adel_o, ades_o, bus_err_o;
  logic [3:0]  ram_sel_o;
  logic [31:0] ram_addr_o, ram_data_o, pc_o, wdata_o;
  logic [4:0]  wd_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_ram_ctrl #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_i         (pc_i),
    .mem_op_i     (mem_op_i),
    .mem_addr_i   (mem_addr_i),
    .store_data_i (store_data_i),
    .wd_i         (wd_i),
    .wreg_i       (wreg_i),
    .wdata_i      (wdata_i),
    .ram_ack_i    (ram_ack_i),
    .ram_data_i   (ram_data_i),
    .ram_ce_o     (ram_ce_o),
    .ram_we_o     (ram_we_o),
    .ram_sel_o    (ram_sel_o),
    .ram_addr_o   (ram_addr_o),
    .ram_data_o   (ram_data_o),
    .stallreq_o   (stallreq_o),
    .pc_o         (pc_o),
    .wd_o         (wd_o),
    .wreg_o       (wreg_o),
    .wdata_o      (wdata_o),
    .adel_o       (adel_o),
    .ades_o       (ades_o),
    .bus_err_o    (bus_err_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mem_op_i     = MEM_NONE;
    mem_addr_i   = 32'h0;
    store_data_i = 32'h0;
    wreg_i       = 1'b0;
    wdata_i      = 32'h0;
    ram_ack_i    = 1'b0;
    ram_data_i   = 32'h0;
  endtask

  // One aligned op: IDLE, waits+1 ACCESS cycles (ack in the last), DONE, then idle.
  task automatic do_op(input string name, input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] sd, input logic [31:0] rdata, input int waits,
                       input logic ld, input logic [3:0] esel, input logic [31:0] eval);
    int stalls;
    stalls = 0;
    cyc();
    mem_op_i = op; mem_addr_i = addr; store_data_i = sd;
    wreg_i = ld; wdata_i = 32'h0BAD0BAD; ram_ack_i = 1'b0;
    #1;
    check({name, ".idle_ce"}, 32'(ram_ce_o), 32'd0);
    stalls += int'(stallreq_o);
    for (int i = 0; i <= waits; i++) begin
      cyc();
      ram_ack_i  = (i == waits);
      ram_data_i = (i == waits) ? rdata : 32'h5A5A5A5A;
      #1;
      check({name, ".ce"}, 32'(ram_ce_o), 32'd1);
      stalls += int'(stallreq_o);
      if (i == waits) begin
        check({name, ".sel"},  32'(ram_sel_o), 32'(esel));
        check({name, ".addr"}, ram_addr_o, {addr[31:2], 2'b00});
        check({name, ".we"},   32'(ram_we_o), 32'(!ld));
        if (!ld) check({name, ".wdata_ram"}, ram_data_o, eval);
      end
    end
    cyc();
    ram_ack_i = 1'b0; ram_data_i = 32'hDEADBEEF;
    #1;
    stalls += int'(stallreq_o);
    check({name, ".done_ce"},  32'(ram_ce_o), 32'd0);
    check({name, ".done_err"}, 32'(bus_err_o), 32'd0);
    check({name, ".wreg"},     32'(wreg_o), 32'(ld));
    if (ld) check({name, ".result"}, wdata_o, eval);
    check({name, ".stall_cycles"}, 32'(stalls), 32'(waits + 2));
    cyc();
    idle_inputs();
    #1;
    check({name, ".after_stall"}, 32'(stallreq_o), 32'd0);
  endtask

  initial begin
    int ce_cycles;
    int stall_cycles;
    rst  = 1'b1;
    pc_i = 32'h0040_0010;
    wd_i = 5'd7;
    idle_inputs();
    repeat (2) cyc();
    #1;
    check("rst.ce",    32'(ram_ce_o),  32'd0);
    check("rst.we",    32'(ram_we_o),  32'd0);
    check("rst.sel",   32'(ram_sel_o), 32'd0);
    check("rst.addr",  ram_addr_o,     32'd0);
    check("rst.data",  ram_data_o,     32'd0);
    check("rst.stall", 32'(stallreq_o), 32'd0);
    check("rst.err",   32'(bus_err_o), 32'd0);
    rst = 1'b0;

    do_op("sb",  MEM_SB,  32'h103, 32'h000000AB, 32'h0,        2, 1'b0, 4'b1000, 32'hABABABAB);
    do_op("lb",  MEM_LB,  32'h202, 32'h0,        32'h0080FF00, 0, 1'b1, 4'b0100, 32'hFFFFFF80);
    do_op("lbu", MEM_LBU, 32'h202, 32'h0,        32'h0080FF00, 0, 1'b1, 4'b0100, 32'h00000080);
    do_op("sh",  MEM_SH,  32'h702, 32'h1234BEEF, 32'h0,        1, 1'b0, 4'b1100, 32'hBEEFBEEF);
    do_op("lh",  MEM_LH,  32'h702, 32'h0,        32'h80017FFF, 0, 1'b1, 4'b1100, 32'hFFFF8001);
    do_op("lhu", MEM_LHU, 32'h700, 32'h0,        32'h80017FFF, 0, 1'b1, 4'b0011, 32'h00007FFF);
    check("pc_o", pc_o, 32'h0040_0010);
    check("wd_o", 32'(wd_o), 32'd7);

    // Misaligned load and store: exception pulse, no request, no stall.
    cyc();
    mem_op_i = MEM_LH; mem_addr_i = 32'h301; wreg_i = 1'b1; wdata_i = 32'h77;
    #1;
    check("adel.pulse", 32'(adel_o),     32'd1);
    check("adel.stall", 32'(stallreq_o), 32'd0);
    check("adel.wreg",  32'(wreg_o),     32'd0);
    check("adel.ce",    32'(ram_ce_o),   32'd0);
    cyc();
    mem_op_i = MEM_SW; mem_addr_i = 32'h402; wreg_i = 1'b0;
    #1;
    check("adel.gone",  32'(adel_o),   32'd0);
    check("ades.pulse", 32'(ades_o),   32'd1);
    check("ades.ce",    32'(ram_ce_o), 32'd0);
    cyc();
    idle_inputs();
    #1;
    check("ades.gone", 32'(ades_o),   32'd0);
    check("mis.no_ce", 32'(ram_ce_o), 32'd0);

    // LW with no ack: four ACCESS cycles, then a one-cycle bus error.
    cyc();
    mem_op_i = MEM_LW; mem_addr_i = 32'h500; wreg_i = 1'b1; wdata_i = 32'h99;
    #1;
    check("to.idle_stall", 32'(stallreq_o), 32'd1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      #1;
      check("to.access_ce", 32'(ram_ce_o), 32'd1);
      check("to.access_err", 32'(bus_err_o), 32'd0);
    end
    cyc();
    #1;
    check("to.err",   32'(bus_err_o),  32'd1);
    check("to.wreg",  32'(wreg_o),     32'd0);
    check("to.ce",    32'(ram_ce_o),   32'd0);
    check("to.stall", 32'(stallreq_o), 32'd0);
    cyc();
    idle_inputs();
    #1;
    check("to.err_gone", 32'(bus_err_o), 32'd0);

    // Reset in the second ACCESS cycle; the late ack must be ignored.
    cyc();
    mem_op_i = MEM_LW; mem_addr_i = 32'h600; store_data_i = 32'h12345678; wreg_i = 1'b1;
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    idle_inputs();
    ram_ack_i = 1'b1; ram_data_i = 32'hCAFECAFE; wdata_i = 32'h55;
    #1;
    check("rr.ce",    32'(ram_ce_o),   32'd0);
    check("rr.sel",   32'(ram_sel_o),  32'd0);
    check("rr.addr",  ram_addr_o,      32'd0);
    check("rr.stall", 32'(stallreq_o), 32'd0);
    cyc();
    ram_ack_i = 1'b0;
    #1;
    check("rr.no_done", wdata_o,        32'h55);
    check("rr.err",     32'(bus_err_o), 32'd0);
    check("rr.ce2",     32'(ram_ce_o),  32'd0);

    // Back-to-back LW 0x400 then SW 0x404, each acked at once: six cycles.
    ce_cycles = 0;
    stall_cycles = 0;
    idle_inputs();
    cyc();
    mem_op_i = MEM_LW; mem_addr_i = 32'h400; wreg_i = 1'b1;
    #1;
    ce_cycles += int'(ram_ce_o); stall_cycles += int'(stallreq_o);
    cyc();
    ram_ack_i = 1'b1; ram_data_i = 32'h11223344;
    #1;
    ce_cycles += int'(ram_ce_o); stall_cycles += int'(stallreq_o);
    check("b2b.lw_addr", ram_addr_o, 32'h400);
    cyc();
    ram_ack_i = 1'b0; ram_data_i = 32'h0;
    #1;
    ce_cycles += int'(ram_ce_o); stall_cycles += int'(stallreq_o);
    check("b2b.lw_data", wdata_o, 32'h11223344);
    check("b2b.lw_wreg", 32'(wreg_o), 32'd1);
    cyc();
    mem_op_i = MEM_SW; mem_addr_i = 32'h404; store_data_i = 32'hCAFEF00D; wreg_i = 1'b0;
    #1;
    ce_cycles += int'(ram_ce_o); stall_cycles += int'(stallreq_o);
    cyc();
    ram_ack_i = 1'b1;
    #1;
    ce_cycles += int'(ram_ce_o); stall_cycles += int'(stallreq_o);
    check("b2b.sw_addr", ram_addr_o, 32'h404);
    check("b2b.sw_data", ram_data_o, 32'hCAFEF00D);
    check("b2b.sw_we",   32'(ram_we_o), 32'd1);
    cyc();
    ram_ack_i = 1'b0;
    #1;
    ce_cycles += int'(ram_ce_o); stall_cycles += int'(stallreq_o);
    check("b2b.ce_cycles",    32'(ce_cycles),    32'd2);
    check("b2b.stall_cycles", 32'(stall_cycles), 32'd4);
    cyc();
    idle_inputs();
    #1;
    check("b2b.no_reissue", 32'(ram_ce_o), 32'd0);
    cyc();
    #1;
    check("b2b.still_idle", 32'(ram_ce_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
